tensor_pingpong_sched: RTL and testbench
========================================

Name: tensor_pingpong_sched

Overview:
Double-buffer scheduler for the tensor RAM, which holds two banks of 2^ADDR_W entries each. The preprocess writer fills one bank while the peak detector scans the other. On each completed frame the block swaps banks, launches the detector, and withholds writes when the reader is still busy so a captured frame is never overwritten. It sits between preprocess, tensor_ram (depth doubled) and peak_detector, all in the pxl_clk domain.

Parameters:
ADDR_W, 10, tensor address width per bank (32x32 grid).
DATA_W, 8, signed tensor element width.
CNT_W, 8, width of the dropped-frame counter.
TIMEOUT_CYCLES, 4096, reader watchdog limit; used only with the optional feature.

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
wr_we_in  in  1  write strobe from preprocess
wr_addr_in  in  ADDR_W  write address from preprocess
wr_data_in  in  DATA_W  signed write data from preprocess
frame_done  in  1  1-cycle pulse from preprocess (tensor_valid): last element of the frame written
rd_addr_in  in  ADDR_W  read address from peak_detector
rd_done  in  1  1-cycle pulse from peak_detector (peak_ready): scan finished
ram_we  out  1  gated write enable to tensor_ram
ram_waddr  out  ADDR_W+1  {wr_bank, wr_addr_in}
ram_wdata  out  DATA_W  wr_data_in passthrough
ram_raddr  out  ADDR_W+1  {rd_bank, rd_addr_in}
rd_start  out  1  1-cycle pulse that launches the peak_detector scan
busy  out  1  reader is active (state != S_IDLE)
drop_count  out  CNT_W  saturating count of discarded frames
timeout_flag  out  1  sticky watchdog flag

Behaviour:
- Registers: state, wr_bank, rd_bank, pending, cap_en, drop_count, timeout_flag, and the watchdog counter.
- Reset (asynchronous, active-low) values:
  - state=S_IDLE, wr_bank=0, rd_bank=1, pending=0, cap_en=1.
  - rd_start=0, busy=0, drop_count=0, timeout_flag=0.
- Write path is combinational with zero latency:
  - ram_we = wr_we_in & cap_en.
  - ram_waddr and ram_wdata pass through (ram_waddr prefixed with wr_bank).
- Read path is combinational: ram_raddr = {rd_bank, rd_addr_in}.
- State S_IDLE:
  - frame_done with cap_en=1 → swap banks (rd_bank<=wr_bank, wr_bank<=~wr_bank), go to S_START.
  - cap_en stays 1.
- State S_START:
  - rd_start=1 for exactly this one cycle, then S_READ.
  - rd_start is registered: frame_done at cycle T → rd_start high at T+1 with the new rd_bank already valid.
- State S_READ:
  - Waits for rd_done.
  - rd_done with pending=0 → S_IDLE.
  - rd_done with pending=1 → swap banks, pending<=0, go to S_START.
  - rd_done is ignored in S_IDLE and S_START.
- frame_done while in S_START or S_READ:
  - cap_en=1 → pending<=1, cap_en<=0. The captured frame is held and later writes are suppressed.
  - cap_en=0 → frame was discarded: drop_count += 1, saturating at all-ones.
  - If pending is 0 after this cycle's update, set cap_en<=1.
- Capture re-arms only at a frame_done boundary, never mid-frame, so torn frames cannot occur.
- Simultaneous rd_done and frame_done in S_READ:
  - pending=0, cap_en=1 → swap, go to S_START, cap_en stays 1 (same as the S_IDLE case).
  - pending=1, cap_en=0 → pending swap executes, the discarded frame is counted, cap_en<=1.
- busy = (state != S_IDLE), registered.
- A second frame_done is never lost: at most one frame is pending, and extra frames are dropped and counted.

Optional Feature:
Macro TENSOR_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_READ and increments each cycle in S_READ.
  - On reaching TIMEOUT_CYCLES-1 without rd_done, the block acts exactly as if rd_done arrived and sets timeout_flag<=1.
  - timeout_flag is sticky until reset.
- Undefined: no counter, timeout_flag tied to 0, S_READ waits indefinitely.

Test Plan:
- Reset, then write addr 5 = -3 and pulse frame_done → ram_waddr=0x005 with ram_we=1; next cycle rd_start=1, rd_bank=0, wr_bank=1; ram_raddr for rd_addr_in=5 is 0x005.
- In S_READ, second frame_done → pending=1; next writes have ram_we=0; rd_done → rd_start 1 cycle later, rd_bank=1, wr_bank=0.
- Pending=1 and a third frame_done → drop_count=1; 256 such drops with CNT_W=8 → drop_count holds 255.
- rd_done and frame_done in the same cycle with pending=0, cap_en=1 → swap, rd_start next cycle, pending stays 0, no drop counted.
- Reset asserted in S_READ with pending=1 → all registers return to reset values immediately, without waiting for a clock edge.
- With TENSOR_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, no rd_done → S_IDLE after 16 cycles in S_READ, timeout_flag=1 until reset.

Source files
------------

// File: rtl/tensor_pingpong_sched.sv
// tensor_pingpong_sched
//   Ping-pong bank scheduler for the tensor RAM (two banks of 2^ADDR_W entries).
//   Preprocess fills the write bank while the peak detector scans the read bank.
//   Each completed frame swaps the banks and launches a scan. If the reader is
//   still busy, the frame is held pending and further writes are gated off.
//   Frames arriving while one is already held are dropped and counted.
//
// Optional build macro: TENSOR_SCHED_TIMEOUT_EN
//   Adds a reader watchdog of TIMEOUT_CYCLES cycles and drives the sticky
//   timeout_flag. Without it, timeout_flag is 0 and the reader may take any time.
//
// Ports
//   clk, reset           pixel clock, async active-low reset
//   wr_we_in/addr/data   write port from preprocess
//   frame_done           last element of a frame written (1-cycle pulse)
//   rd_addr_in           read address from peak_detector
//   rd_done              peak_detector scan finished (1-cycle pulse)
//   ram_we/waddr/wdata   gated write port to tensor_ram, {wr_bank, addr}
//   ram_raddr            read address to tensor_ram, {rd_bank, addr}
//   rd_start             registered 1-cycle scan launch
//   busy                 reader active (registered)
//   drop_count           saturating discarded-frame count
//   timeout_flag         sticky watchdog flag
module tensor_pingpong_sched #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_we_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              rd_done,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W:0]   ram_raddr,
  output logic              rd_start,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ} state_t;

  state_t           state, state_nx;
  logic             wr_bank, wr_bank_nx;
  logic             rd_bank, rd_bank_nx;
  logic             pending, pending_nx;
  logic             cap_en, cap_en_nx;
  logic [CNT_W-1:0] drop_nx;
  logic             fd_used;
  logic             rd_evt;

  // Zero-latency write/read address muxing.
  assign ram_we    = wr_we_in & cap_en;
  assign ram_waddr = {wr_bank, wr_addr_in};
  assign ram_wdata = wr_data_in;
  assign ram_raddr = {rd_bank, rd_addr_in};

`ifdef TENSOR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  // Counter is 0 on the first S_READ cycle, so the hit lands on the
  // TIMEOUT_CYCLES-th cycle spent reading.
  assign wd_hit = (state == S_READ) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign rd_evt = rd_done | wd_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wd_cnt <= '0;
    else if (state != S_READ)  wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  timeout_flag <= 1'b0;
    else if (wd_hit && !rd_done) timeout_flag <= 1'b1;
  end
`else
  // The watchdog limit only matters when the watchdog is built in.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rd_evt       = rd_done;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    wr_bank_nx = wr_bank;
    rd_bank_nx = rd_bank;
    pending_nx = pending;
    cap_en_nx  = cap_en;
    drop_nx    = drop_count;
    fd_used    = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_done && cap_en) begin
          rd_bank_nx = wr_bank;
          wr_bank_nx = ~wr_bank;
          fd_used    = 1'b1;
          state_nx   = S_START;
        end
      end
      S_START: state_nx = S_READ;
      S_READ: begin
        if (rd_evt) begin
          if (pending) begin
            rd_bank_nx = wr_bank;
            wr_bank_nx = ~wr_bank;
            pending_nx = 1'b0;
            state_nx   = S_START;
          end else if (frame_done && cap_en) begin
            // Reader frees up on the same cycle a frame lands: launch directly.
            rd_bank_nx = wr_bank;
            wr_bank_nx = ~wr_bank;
            fd_used    = 1'b1;
            state_nx   = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // A frame that did not launch a scan is either held or discarded.
    // Capture only re-arms here, at a frame boundary, so no torn frames.
    if (frame_done && !fd_used) begin
      if (cap_en) begin
        pending_nx = 1'b1;
        cap_en_nx  = 1'b0;
      end else begin
        if (drop_count != '1) drop_nx = drop_count + CNT_W'(1);
        if (!pending_nx) cap_en_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      pending    <= 1'b0;
      cap_en     <= 1'b1;
      drop_count <= '0;
      rd_start   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_bank    <= wr_bank_nx;
      rd_bank    <= rd_bank_nx;
      pending    <= pending_nx;
      cap_en     <= cap_en_nx;
      drop_count <= drop_nx;
      rd_start   <= (state_nx == S_START);
      busy       <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_tensor_pingpong_sched.sv
// Self-checking bench for tensor_pingpong_sched. Expected read addresses of each
// scan launch are queued when the launching stimulus is driven and popped when
// rd_start appears.
module tb_tensor_pingpong_sched;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_we_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              frame_done;
  logic [ADDR_W-1:0] rd_addr_in;
  logic              rd_done;
  logic              ram_we;
  logic [ADDR_W:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W:0]   ram_raddr;
  logic              rd_start;
  logic              busy;
  logic [CNT_W-1:0]  drop_count;
  logic              timeout_flag;

  int n_pass  = 0;
  int n_total = 0;

  logic [ADDR_W:0] exp_q[$];
  logic            tb_wr_bank;

  tensor_pingpong_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_we_in(wr_we_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .frame_done(frame_done), .rd_addr_in(rd_addr_in), .rd_done(rd_done),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .rd_start(rd_start), .busy(busy),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    wr_we_in   = 1'b0;
    wr_addr_in = ADDR_W'(5);
    wr_data_in = '0;
    frame_done = 1'b0;
    rd_addr_in = ADDR_W'(5);
    rd_done    = 1'b0;
    exp_q.delete();
    tb_wr_bank = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Model of one bank swap: the current write bank becomes the read bank.
  task automatic push_swap();
    exp_q.push_back({tb_wr_bank, rd_addr_in});
    tb_wr_bank = ~tb_wr_bank;
  endtask

  // Scoreboard pop: wait for rd_start and compare its latency and read address.
  task automatic wait_rd_start(input string name, input int exp_lat);
    int n = 0;
    logic [ADDR_W:0] exp;
    while (!rd_start && n < 8) begin tick(); n++; end
    n_total++;
    if (!rd_start || exp_q.size() == 0) begin
      $display("FAIL %s rd_start: not seen within %0d cycles (queue %0d)", name, n, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (ram_raddr !== exp || n != exp_lat)
        $display("FAIL %s rd_start: raddr %0h lat %0d, want raddr %0h lat %0d", name, ram_raddr, n, exp, exp_lat);
      else n_pass++;
    end
  endtask

  // Pulse frame_done from idle and stop on the first S_READ cycle.
  task automatic launch(input string name);
    frame_done = 1'b1;
    push_swap();
    tick();
    frame_done = 1'b0;
    wait_rd_start(name, 0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    wr_we_in = 1'b1; #1;
    n_total++;
    if (busy !== 1'b0 || rd_start !== 1'b0 || drop_count !== '0 || timeout_flag !== 1'b0)
      $display("FAIL reset_regs: busy %b rd_start %b drop %0d tmo %b, want 0 0 0 0", busy, rd_start, drop_count, timeout_flag);
    else n_pass++;
    n_total++;
    if (ram_raddr !== 11'h405 || ram_waddr !== 11'h005 || ram_we !== 1'b1)
      $display("FAIL reset_banks: raddr %0h waddr %0h we %b, want 405 005 1", ram_raddr, ram_waddr, ram_we);
    else n_pass++;
    wr_we_in = 1'b0;
  endtask

  task automatic test_first_frame();
    do_reset();
    wr_we_in = 1'b1; wr_data_in = 8'hFD; frame_done = 1'b1; #1;
    n_total++;
    if (ram_we !== 1'b1 || ram_waddr !== 11'h005 || ram_wdata !== 8'hFD)
      $display("FAIL first_write: we %b waddr %0h wdata %0h, want 1 005 fd", ram_we, ram_waddr, ram_wdata);
    else n_pass++;
    push_swap();
    tick();
    frame_done = 1'b0;
    wait_rd_start("first_frame", 0);
    n_total++;
    if (ram_waddr !== 11'h405 || busy !== 1'b1)
      $display("FAIL first_wbank: waddr %0h busy %b, want 405 1", ram_waddr, busy);
    else n_pass++;
    tick();
    n_total++;
    if (rd_start !== 1'b0)
      $display("FAIL first_pulse: rd_start %b after one cycle, want 0", rd_start);
    else n_pass++;
  endtask

  // Continues from test_first_frame: reader is in S_READ, capture armed.
  task automatic test_pending();
    frame_done = 1'b1; #1;
    n_total++;
    if (ram_we !== 1'b1)
      $display("FAIL pend_last_write: we %b, want 1", ram_we);
    else n_pass++;
    tick();
    frame_done = 1'b0; #1;
    n_total++;
    if (ram_we !== 1'b0)
      $display("FAIL pend_gate: we %b, want 0", ram_we);
    else n_pass++;
    rd_done = 1'b1;
    push_swap();
    tick();
    rd_done = 1'b0;
    wait_rd_start("pending_swap", 0);
    n_total++;
    if (ram_waddr[ADDR_W] !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL pend_swap_w: wbank %b we %b, want 0 0", ram_waddr[ADDR_W], ram_we);
    else n_pass++;
    tick();
    // Capture was not re-armed: this frame is discarded and re-arms it.
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0; #1;
    n_total++;
    if (drop_count !== 8'd1 || ram_we !== 1'b1)
      $display("FAIL rearm: drop %0d we %b, want 1 1", drop_count, ram_we);
    else n_pass++;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; wr_we_in = 1'b0;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL pend_idle: busy %b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_drop();
    int exp_drop;
    do_reset();
    launch("drop_launch");
    frame_done = 1'b1; tick();   // held pending
    tick();                      // first drop
    frame_done = 1'b0; #1;
    n_total++;
    if (drop_count !== 8'd1)
      $display("FAIL drop_one: drop %0d, want 1", drop_count);
    else n_pass++;
    frame_done = 1'b1;
    repeat (300) tick();
    frame_done = 1'b0;
    exp_drop = (1 + 300 > 255) ? 255 : 1 + 300;
    wr_we_in = 1'b1; #1;
    n_total++;
    if (drop_count !== CNT_W'(exp_drop) || ram_we !== 1'b0)
      $display("FAIL drop_sat: drop %0d we %b, want %0d 0", drop_count, ram_we, exp_drop);
    else n_pass++;
    wr_we_in = 1'b0;
  endtask

  task automatic test_simul();
    do_reset();
    launch("simul_launch");
    frame_done = 1'b1; rd_done = 1'b1;
    push_swap();
    tick();
    frame_done = 1'b0; rd_done = 1'b0;
    wait_rd_start("simul_swap", 0);
    n_total++;
    if (drop_count !== '0)
      $display("FAIL simul_nodrop: drop %0d, want 0", drop_count);
    else n_pass++;
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; wr_we_in = 1'b1; #1;
    n_total++;
    if (busy !== 1'b0 || ram_we !== 1'b1)
      $display("FAIL simul_nopend: busy %b we %b, want 0 1", busy, ram_we);
    else n_pass++;
    wr_we_in = 1'b0;
  endtask

  task automatic test_simul_pending();
    do_reset();
    launch("simulp_launch");
    frame_done = 1'b1; tick();
    rd_done = 1'b1;
    push_swap();
    tick();
    frame_done = 1'b0; rd_done = 1'b0;
    wait_rd_start("simulp_swap", 0);
    wr_we_in = 1'b1; #1;
    n_total++;
    if (drop_count !== 8'd1 || ram_we !== 1'b1 || ram_waddr[ADDR_W] !== tb_wr_bank)
      $display("FAIL simulp: drop %0d we %b wbank %b, want 1 1 %b", drop_count, ram_we, ram_waddr[ADDR_W], tb_wr_bank);
    else n_pass++;
    wr_we_in = 1'b0;
  endtask

  task automatic test_idle_rd_done();
    do_reset();
    rd_done = 1'b1;
    tick(); tick();
    rd_done = 1'b0;
    n_total++;
    if (busy !== 1'b0 || rd_start !== 1'b0)
      $display("FAIL idle_rd_done: busy %b rd_start %b, want 0 0", busy, rd_start);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    launch("areset_launch");
    frame_done = 1'b1; tick(); tick();   // pending, then one drop
    frame_done = 1'b0;
    wr_we_in = 1'b1;
    #2 reset = 1'b0;
    #1;                                  // mid-cycle, no clock edge yet
    n_total++;
    if (busy !== 1'b0 || drop_count !== '0 || ram_raddr !== 11'h405 || ram_waddr !== 11'h005 || ram_we !== 1'b1)
      $display("FAIL async_reset: busy %b drop %0d raddr %0h waddr %0h we %b, want 0 0 405 005 1",
               busy, drop_count, ram_raddr, ram_waddr, ram_we);
    else n_pass++;
    wr_we_in = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_watchdog();
    int n = 0;
    do_reset();
    launch("wd_launch");
`ifdef TENSOR_SCHED_TIMEOUT_EN
    while (busy && n < 100) begin tick(); n++; end
    n_total++;
    if (n != 16 || timeout_flag !== 1'b1)
      $display("FAIL watchdog: idle after %0d cycles tmo %b, want 16 1", n, timeout_flag);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (timeout_flag !== 1'b1)
      $display("FAIL watchdog_sticky: tmo %b, want 1", timeout_flag);
    else n_pass++;
`else
    repeat (40) tick();
    n_total++;
    if (busy !== 1'b1 || timeout_flag !== 1'b0)
      $display("FAIL no_watchdog: busy %b tmo %b, want 1 0", busy, timeout_flag);
    else n_pass++;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL no_watchdog_done: busy %b, want 0", busy);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pending();
    test_drop();
    test_simul();
    test_simul_pending();
    test_idle_rd_done();
    test_async_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
